// File: rtl/cdf_equalize_map_if.sv
// Bus bundle between the CDF-to-LUT mapper and its memories/controller.
// The slave modport is the mapper's view; master is the surrounding system.
`timescale 1ns/1ps
interface cdf_equalize_map_if;
    logic         start;
    logic [19:0]  Cdf_min;
    logic [19:0]  PixelCount;
    logic [127:0] CDF_ReadBus;
    logic [15:0]  CDF_ReadAddress;
    logic [127:0] LUT_WriteBus;
    logic [15:0]  LUT_WriteAddress;
    logic         LUT_WriteEnable;
    logic         busy;
    logic         done;

    modport slave (
        input  start, Cdf_min, PixelCount, CDF_ReadBus,
        output CDF_ReadAddress, LUT_WriteBus, LUT_WriteAddress,
               LUT_WriteEnable, busy, done
    );

    modport master (
        output start, Cdf_min, PixelCount, CDF_ReadBus,
        input  CDF_ReadAddress, LUT_WriteBus, LUT_WriteAddress,
               LUT_WriteEnable, busy, done
    );
endinterface

// File: rtl/cdf_equalize_map.sv
// Builds the 256-entry histogram-equalization LUT from the stored CDF,
// one bin at a time through an 8-step restoring divider.
`timescale 1ns/1ps
module cdf_equalize_map #(
    parameter logic [15:0] CDF_BASE = 16'h0000,
    parameter logic [15:0] LUT_BASE = 16'h0000
) (
    input logic              clock,
    input logic              reset,
    cdf_equalize_map_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_CAPTURE, S_SETUP, S_DIV, S_WRITE, S_DONE
    } state_t;

    state_t       r_state;
    logic [5:0]   r_k;
    logic [1:0]   r_lane;
    logic [2:0]   r_step;
    logic [127:0] r_word;
    logic [19:0]  r_cmin;
    logic [19:0]  r_npix;
    logic [27:0]  r_rem;
    logic [7:0]   r_quot;
    logic         r_zero;
    logic         r_max;
    logic [127:0] r_pack;
    logic [15:0]  r_rd_addr;
    logic [15:0]  r_wr_addr;
    logic         r_we;
    logic         r_busy;
    logic         r_done;

    logic [19:0]  w_cdf;
    logic [19:0]  w_den;
    logic [19:0]  w_x;
    logic [27:0]  w_num;
    logic [27:0]  w_den_sh;
    logic         w_ge;
    logic [7:0]   w_quot_next;
    logic [7:0]   w_result;

    assign w_cdf       = r_word[{r_lane, 5'd0} +: 20];
    assign w_den       = r_npix - r_cmin;
    assign w_x         = w_cdf - r_cmin;
    assign w_num       = {w_x, 8'd0} - {8'd0, w_x};
    assign w_den_sh    = {8'd0, w_den} << r_step;
    assign w_ge        = (r_rem >= w_den_sh);
    assign w_quot_next = {r_quot[6:0], w_ge};
    // Zero clamp outranks the saturate clamp, both flags may be set together.
    assign w_result    = r_zero ? 8'h00 : (r_max ? 8'hFF : w_quot_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_lane    <= '0;
            r_step    <= '0;
            r_word    <= '0;
            r_cmin    <= '0;
            r_npix    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_zero    <= 1'b0;
            r_max     <= 1'b0;
            r_pack    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_ISSUE;
                        r_busy    <= 1'b1;
                        r_k       <= '0;
                        r_lane    <= '0;
                        r_cmin    <= bus.Cdf_min;
                        r_npix    <= bus.PixelCount;
                        r_rd_addr <= CDF_BASE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_word  <= bus.CDF_ReadBus;
                    r_lane  <= '0;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_rem   <= w_num;
                    r_quot  <= '0;
                    r_step  <= 3'd7;
                    r_zero  <= (w_den == 20'd0) || (w_cdf < r_cmin);
                    r_max   <= (w_cdf > r_npix);
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    if (w_ge) r_rem <= r_rem - w_den_sh;
                    r_quot <= w_quot_next;
                    r_step <= r_step - 3'd1;
                    if (r_step == 3'd0) begin
                        r_pack <= {w_result, r_pack[127:8]};
                        if (r_lane == 2'd3) begin
                            r_k <= r_k + 6'd1;
                            if (r_k[1:0] == 2'd3) begin
                                r_state   <= S_WRITE;
                                r_we      <= 1'b1;
                                r_wr_addr <= LUT_BASE + {12'd0, r_k[5:2]};
                            end else begin
                                r_state   <= S_ISSUE;
                                r_rd_addr <= CDF_BASE + {10'd0, r_k + 6'd1};
                            end
                        end else begin
                            r_lane  <= r_lane + 2'd1;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    // r_k has wrapped to 0 only after the final CDF word.
                    if (r_k == 6'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= S_ISSUE;
                        r_rd_addr <= CDF_BASE + {10'd0, r_k};
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.CDF_ReadAddress  = r_rd_addr;
    assign bus.LUT_WriteBus     = r_pack;
    assign bus.LUT_WriteAddress = r_wr_addr;
    assign bus.LUT_WriteEnable  = r_we;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
endmodule

// File: tb/tb_cdf_equalize_map.sv
// Directed bench for cdf_equalize_map: reset, ramp/clamp/flat/two-level LUTs,
// strobe timing, ignored restart and mid-build reset.
`timescale 1ns/1ps
module tb_cdf_equalize_map;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cdf_equalize_map_if bus();

    cdf_equalize_map #(.CDF_BASE(16'h0000), .LUT_BASE(16'h0000)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [127:0] cdf_mem [0:63];
    always @(posedge clock)
        bus.CDF_ReadBus <= (bus.CDF_ReadAddress < 16'd64) ? cdf_mem[bus.CDF_ReadAddress[5:0]] : '1;

    int tests = 0;
    int fails = 0;

    int           wcnt, done_cnt, done_cyc, busy_cnt, consec;
    int           wcyc  [0:31];
    logic [15:0]  waddr [0:31];
    logic [127:0] lut_got [0:15];
    logic         prev_we, busy_at_done;
    logic [15:0]  rd1, rd2, rd39, rd2410, rd2449;
    logic [15:0]  post_rd, post_waddr;
    logic [127:0] post_wbus;
    logic [2:0]   post_ctl;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bin(input int v, input logic [19:0] val);
        cdf_mem[v / 4][32 * (v % 4) +: 32] = {12'hA5C, val};
    endtask

    task automatic load_ramp();
        for (int v = 0; v < 256; v++) set_bin(v, 20'(v + 1));
    endtask

    function automatic logic [127:0] ramp_word(input int m);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8 * i +: 8] = 8'(16 * m + i);
        return w;
    endfunction

    task automatic run(input int total, input int rst_c, input int restart_c, input int extra_c,
                       input logic [19:0] cmin, input logic [19:0] npix);
        wcnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; consec = 0;
        prev_we = 1'b0; busy_at_done = 1'bx;
        for (int i = 0; i < 16; i++) lut_got[i] = {8{16'hDEAD}};
        @(negedge clock);
        bus.start = 1'b1;
        bus.Cdf_min = cmin;
        bus.PixelCount = npix;
        for (int c = 1; c <= total; c++) begin
            @(negedge clock);
            if (bus.LUT_WriteEnable) begin
                if (prev_we) consec++;
                if (wcnt < 32) begin
                    wcyc[wcnt]  = c;
                    waddr[wcnt] = bus.LUT_WriteAddress;
                end
                wcnt++;
                lut_got[bus.LUT_WriteAddress[3:0]] = bus.LUT_WriteBus;
            end
            prev_we = bus.LUT_WriteEnable;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                busy_at_done = bus.busy;
            end
            if (bus.busy) busy_cnt++;
            if (c == 1)    rd1    = bus.CDF_ReadAddress;
            if (c == 2)    rd2    = bus.CDF_ReadAddress;
            if (c == 39)   rd39   = bus.CDF_ReadAddress;
            if (c == 2410) rd2410 = bus.CDF_ReadAddress;
            if (c == 2449) rd2449 = bus.CDF_ReadAddress;
            if (c == rst_c + 1) begin
                post_rd    = bus.CDF_ReadAddress;
                post_wbus  = bus.LUT_WriteBus;
                post_waddr = bus.LUT_WriteAddress;
                post_ctl   = {bus.LUT_WriteEnable, bus.busy, bus.done};
            end
            // Latched limits must not follow later input changes.
            if (c == 1 || c == restart_c + 1) begin
                bus.Cdf_min    = 20'd7;
                bus.PixelCount = 20'd9;
            end
            if (c == restart_c) begin
                bus.Cdf_min    = cmin;
                bus.PixelCount = npix;
            end
            bus.start = (c == restart_c) || (c == extra_c);
            reset     = (c == rst_c);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.Cdf_min = '0;
        bus.PixelCount = '0;
        for (int k = 0; k < 64; k++) cdf_mem[k] = '0;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_rdaddr", bus.CDF_ReadAddress, 16'h0);
        check("rst_wbus",   bus.LUT_WriteBus, 128'h0);
        check("rst_waddr",  bus.LUT_WriteAddress, 16'h0);
        check("rst_we",     bus.LUT_WriteEnable, 1'b0);
        check("rst_busy",   bus.busy, 1'b0);
        check("rst_done",   bus.done, 1'b0);

        // start together with reset: reset wins
        bus.start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 1'b0);
        @(negedge clock);
        check("rst_start_busy2", bus.busy, 1'b0);

        // Ramp with timing, latched limits, and an ignored start at cycle 1000
        load_ramp();
        run(2455, -5, -1, 1000, 20'd1, 20'd256);
        check("ramp_rd_c1",    rd1, 16'd0);
        check("ramp_rd_c2",    rd2, 16'd0);
        check("ramp_rd_c39",   rd39, 16'd1);
        check("ramp_rd_c2410", rd2410, 16'd63);
        check("ramp_rd_c2449", rd2449, 16'd63);
        check("ramp_wcnt",     wcnt, 16);
        check("ramp_consec",   consec, 0);
        for (int m = 0; m < 16; m++) begin
            check($sformatf("ramp_wcyc%0d", m),  wcyc[m], 153 * (m + 1));
            check($sformatf("ramp_waddr%0d", m), waddr[m], 16'(m));
            check($sformatf("ramp_lut%0d", m),   lut_got[m], ramp_word(m));
        end
        check("ramp_done_cnt",  done_cnt, 1);
        check("ramp_done_cyc",  done_cyc, 2449);
        check("ramp_busy_done", busy_at_done, 1'b0);
        check("ramp_busy_cnt",  busy_cnt, 2448);

        // Reset at cycle 500, restart at cycle 510
        run(2965, 500, 510, -1, 20'd1, 20'd256);
        check("mid_rdaddr", post_rd, 16'h0);
        check("mid_wbus",   post_wbus, 128'h0);
        check("mid_waddr",  post_waddr, 16'h0);
        check("mid_ctl",    post_ctl, 3'b000);
        check("mid_wcnt",   wcnt, 19);
        for (int j = 0; j < 19; j++)
            check($sformatf("mid_wcyc%0d", j), wcyc[j], (j < 3) ? 153 * (j + 1) : 510 + 153 * (j - 2));
        for (int m = 0; m < 16; m++)
            check($sformatf("mid_lut%0d", m), lut_got[m], ramp_word(m));
        check("mid_done_cnt", done_cnt, 1);
        check("mid_done_cyc", done_cyc, 510 + 2449);
        check("mid_busy_cnt", busy_cnt, 500 + 2448);

        // Single intensity: den = 0
        for (int v = 0; v < 256; v++) set_bin(v, (v < 100) ? 20'd0 : 20'd4096);
        run(2455, -5, -1, -1, 20'd4096, 20'd4096);
        check("flat_wcnt", wcnt, 16);
        for (int m = 0; m < 16; m++)
            check($sformatf("flat_lut%0d", m), lut_got[m], 128'h0);

        // Two level
        for (int v = 0; v < 256; v++) set_bin(v, (v < 128) ? 20'd10 : 20'd20);
        run(2455, -5, -1, -1, 20'd10, 20'd20);
        for (int m = 0; m < 16; m++)
            check($sformatf("two_lut%0d", m), lut_got[m], (m < 8) ? 128'h0 : {128{1'b1}});

        // Clamps on a ramp: bin 5 above N, bin 6 below Cdf_min
        load_ramp();
        set_bin(5, 20'd300);
        set_bin(6, 20'd0);
        run(2455, -5, -1, -1, 20'd1, 20'd256);
        begin
            logic [127:0] w0;
            w0 = ramp_word(0);
            w0[47:40] = 8'hFF;
            w0[55:48] = 8'h00;
            check("clamp_lut0", lut_got[0], w0);
        end
        for (int m = 1; m < 16; m++)
            check($sformatf("clamp_lut%0d", m), lut_got[m], ramp_word(m));
        check("clamp_done_cyc", done_cyc, 2449);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdf_equalize_map.md
# cdf_equalize_map

Reads back the cumulative histogram that the CDF pipeline writes to output memory and turns it into the 256-entry histogram-equalization lookup table. For each bin it computes lut(v) = floor((cdf(v) − Cdf_min) × 255 / (PixelCount − Cdf_min)) with a sequential 8-step divider. It writes the packed 8-bit results to LUT memory. It is the consumer side of the CDF store stage, started once the CDF pipeline reports done.

## Interface
- CDF_BASE, 16'h0000, word address of CDF bins 0–3 in CDF memory
- LUT_BASE, 16'h0000, word address of LUT entries 0–15 in LUT memory
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a LUT build; sampled only in IDLE
- Cdf_min  in  20  smallest nonzero CDF value; latched at start
- PixelCount  in  20  total pixel count N (the last CDF value); latched at start
- CDF_ReadBus  in  128  CDF memory read data; valid one cycle after the address
- CDF_ReadAddress  out  16  CDF memory read address
- LUT_WriteBus  out  128  LUT write data, 16 entries of 8 bits
- LUT_WriteAddress  out  16  LUT write address
- LUT_WriteEnable  out  1  one-cycle write strobe
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final LUT write

## Operation
- CDF layout: word CDF_BASE+k holds bins 4k..4k+3. Bin 4k+j occupies bits [32j+19:32j]; bits [32j+31:32j+20] are ignored. There are 64 words, k = 0..63.
- LUT layout: word LUT_BASE+m holds bins 16m..16m+15. Bin 16m+i occupies bits [8i+7:8i]. There are 16 words.
- FSM states:
  - IDLE → ISSUE on start.
  - ISSUE: drive CDF_ReadAddress = CDF_BASE+k.
  - CAPTURE: latch CDF_ReadBus into a 128-bit word register.
  - SETUP: per lane, form the numerator and denominator and apply the clamps.
  - DIV: 8 cycles.
  - After lane 3, go to WRITE if k%4 == 3, otherwise go to ISSUE with k+1.
  - WRITE: one cycle. After the last WRITE go to DONE, otherwise go to ISSUE.
  - DONE: one cycle, then IDLE.
- SETUP arithmetic:
  - den = PixelCount − Cdf_min (20 bits).
  - num = (cdf − Cdf_min) × 255, 28 bits unsigned, computed as (x<<8) − x.
- SETUP clamps, in priority order:
  1. If den == 0, the result is 0.
  2. Else if cdf < Cdf_min, the result is 0.
  3. Else if cdf > PixelCount, the result is 255.
  4. Otherwise divide.
  - Clamped lanes still spend 8 DIV cycles so timing stays fixed.
- Divider: restoring division with remainder r initialised to num. In iteration s = 7..0, if r ≥ den<<s then r −= den<<s and quotient bit s = 1. num < 256×den is guaranteed after the clamps, so the 8-bit quotient is exact floor.
- Results are shifted into a 128-bit pack register at lane position bin%16. LUT_WriteBus is the pack register, valid during WRITE.
- start while busy is ignored. Cdf_min and PixelCount changes after start have no effect.

## Timing
- Reset values: CDF_ReadAddress = 0, LUT_WriteBus = 0, LUT_WriteAddress = 0, LUT_WriteEnable = 0, busy = 0, done = 0. The FSM is in IDLE and all counters are 0.
- Per CDF word: ISSUE 1 cycle + CAPTURE 1 cycle + 4 × (SETUP 1 + DIV 8) = 38 cycles.
- Per LUT word: 4 CDF words + WRITE 1 cycle = 153 cycles.
- Whole build: 16 × 153 = 2448 cycles.
- Start is sampled at edge 0. ISSUE for k=0 is cycle 1. The m-th write (m = 0..15) happens in cycle 153(m+1). done is high in cycle 2449. busy is high in cycles 1..2448 and low in the done cycle.
- CDF_ReadAddress holds its last value outside ISSUE. LUT_WriteAddress = LUT_BASE+m is valid with LUT_WriteEnable.
- LUT_WriteEnable is high exactly 16 times per build, never twice consecutively, and never outside WRITE.
- Reset mid-operation: on the next edge all outputs return to their reset values and the FSM goes to IDLE. No partial or extra LUT write is issued. A later start rebuilds from bin 0.
- start and reset in the same cycle: reset wins.
- start in the same cycle as done is ignored, because the FSM is not yet in IDLE.

## Test plan
- Ramp: cdf(v) = v+1, PixelCount = 256, Cdf_min = 1 → lut(v) = v for all 256 bins. Word m = bytes 16m..16m+15 ascending.
- Single intensity: cdf = 0 for v < 100 and 4096 for v ≥ 100, Cdf_min = 4096, PixelCount = 4096 → den = 0, all 16 LUT words = 0.
- Two level: cdf = 10 for v < 128 and 20 for v ≥ 128, Cdf_min = 10, PixelCount = 20 → LUT words 0–7 all 8'h00, words 8–15 all 8'hFF.
- Clamps: in the ramp image, set bin 5 cdf = 300 (> N) and bin 6 cdf = 0 (< Cdf_min) → lut(5) = 255, lut(6) = 0, all other bins unchanged.
- Timing and handshake: CDF reads cover addresses CDF_BASE..+63, each in ISSUE only. There are 16 write strobes at cycles 153, 306, …, 2448 with addresses LUT_BASE..+15. done is a single pulse at cycle 2449. A second start at cycle 1000 is ignored.
- Reset at cycle 500, then start at cycle 510: outputs are zero and busy is low from cycle 501, with no write strobe between 500 and 510. The rebuilt LUT matches the ramp result exactly, and done occurs at cycle 510+2449.
